maple_in: RTL and testbench

- Maple bus receiver: decodes the two-wire SDCKA (pin1) / SDCKB (pin5) bus into start/end framing events and a byte stream for the RX FIFO.
- Counterpart of the existing Maple transmitter. It sits on the same bus pins and listens while the transmitter's output enable is low.
- Samples raw pins through synchronisers. Recovers bits on falling clock-line edges. Pushes complete bytes MSB-first.

---
 rtl/maple_in_if.sv | 30 +++
 rtl/maple_in.sv | 220 ++++++++++++++++++++++
 tb/tb_maple_in.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/maple_in_if.sv
// Maple receiver port bundle: raw bus pins and control in, FIFO push and status out.
//   pin1/pin5  raw SDCKA/SDCKB from the pads (asynchronous)
//   enable     1 = listen, 0 = hold idle while our own transmitter drives the bus
//   fifo_full  RX FIFO cannot take a byte
//   data/data_valid                          byte push to the RX FIFO
//   start_seen/end_seen/error                one-cycle framing events
//   overflow (sticky), busy (frame in progress)
interface maple_in_if;
    logic       pin1;
    logic       pin5;
    logic       enable;
    logic       fifo_full;
    logic [7:0] data;
    logic       data_valid;
    logic       start_seen;
    logic       end_seen;
    logic       error;
    logic       overflow;
    logic       busy;

    modport slave (
        input  pin1, pin5, enable, fifo_full,
        output data, data_valid, start_seen, end_seen, error, overflow, busy
    );

    modport master (
        output pin1, pin5, enable, fifo_full,
        input  data, data_valid, start_seen, end_seen, error, overflow, busy
    );
endinterface

// File: rtl/maple_in.sv
// Maple bus receiver: synchronises SDCKA/SDCKB, detects start/end patterns and
// recovers data bits on falling clock-line edges, pushing bytes MSB-first.
//   clk, rst (synchronous, active-low)
//   bus  maple_in_if.slave (pins, enable, fifo_full in; data/strobes/status out)
module maple_in #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TO_W    = 13
) (
    input  logic       clk,
    input  logic       rst,
    maple_in_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_END} state_t;

    // Pin vectors: bit 0 = pin1 (SDCKA), bit 1 = pin5 (SDCKB)
    logic [1:0]      sync1_q, sync2_q, prev_q;
    state_t          state_q, state_d;
    logic [2:0]      start_cnt_q, start_cnt_d;
    logic [2:0]      end_cnt_q, end_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            phase_q, phase_d;      // 0 = phase A (clock pin1), 1 = phase B
    logic [7:0]      shreg_q, shreg_d;
    logic            pend_q, pend_d;        // full byte waiting to be pushed
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d, start_q, start_d, end_q, end_d;
    logic            err_q, err_d, ovf_q, ovf_d, busy_q;

    logic fall1, rise1, fall5, rise5, any_edge, s1, s5, abort;

    assign s1       = sync2_q[0];
    assign s5       = sync2_q[1];
    assign fall1    = prev_q[0] & ~sync2_q[0];
    assign rise1    = ~prev_q[0] & sync2_q[0];
    assign fall5    = prev_q[1] & ~sync2_q[1];
    assign rise5    = ~prev_q[1] & sync2_q[1];
    assign any_edge = fall1 | rise1 | fall5 | rise5;

    // Synchronisers and edge history; keep running regardless of enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            sync1_q <= {bus.pin5, bus.pin1};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            start_cnt_q <= 3'd0;
            end_cnt_q   <= 3'd0;
            bit_cnt_q   <= 3'd0;
            phase_q     <= 1'b0;
            shreg_q     <= 8'h00;
            pend_q      <= 1'b0;
            to_q        <= '0;
            data_q      <= 8'h00;
            dv_q        <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            end_cnt_q   <= end_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_q     <= phase_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            to_q        <= to_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            start_q     <= start_d;
            end_q       <= end_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        end_cnt_d   = end_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        phase_d     = phase_q;
        shreg_d     = shreg_q;
        pend_d      = 1'b0;
        to_d        = any_edge ? '0 : to_q + TO_W'(1);
        data_d      = data_q;
        dv_d        = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        err_d       = 1'b0;
        ovf_d       = ovf_q;
        abort       = 1'b0;

        // Byte completed last cycle: push it or drop it as an overflow
        if (pend_q) begin
            if (!bus.fifo_full) begin
                dv_d   = 1'b1;
                data_d = shreg_q;
            end else begin
                ovf_d = 1'b1;
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                to_d = '0;
                if (fall1 && s5) begin
                    state_d     = S_START;
                    start_cnt_d = 3'd0;
                end
            end
            S_START: begin
                if (fall1 && fall5) begin
                    abort = 1'b1;
                end else if (rise1) begin
                    if (start_cnt_q == 3'd4) begin
                        start_d   = 1'b1;
                        ovf_d     = 1'b0;
                        state_d   = S_DATA;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (fall5 && start_cnt_q != 3'd7) begin
                    start_cnt_d = start_cnt_q + 3'd1;
                end
            end
            S_DATA: begin
                if (fall1 && fall5) begin
                    abort = 1'b1;
                end else if (!phase_q) begin
                    if (fall1) begin
                        shreg_d   = {shreg_q[6:0], s5};
                        phase_d   = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        pend_d    = (bit_cnt_q == 3'd7);
                    end else if (fall5) begin
                        // pin5 falling on a byte boundary is the end pattern
                        if (bit_cnt_q == 3'd0) begin
                            state_d   = S_END;
                            end_cnt_d = 3'd0;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end else begin
                    if (fall5) begin
                        shreg_d   = {shreg_q[6:0], s1};
                        phase_d   = 1'b0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        pend_d    = (bit_cnt_q == 3'd7);
                    end else if (fall1) begin
                        abort = 1'b1;
                    end
                end
            end
            S_END: begin
                if (fall1 && fall5) begin
                    abort = 1'b1;
                end else if (rise5) begin
                    if (end_cnt_q == 3'd2) begin
                        end_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (fall1 && end_cnt_q != 3'd7) begin
                    end_cnt_d = end_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !any_edge && to_q == TO_W'(TIMEOUT - 1)) begin
            abort = 1'b1;
        end

        if (abort) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end

        // Own transmission in progress: drop everything silently
        if (!bus.enable) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            dv_d    = 1'b0;
            data_d  = data_q;
            start_d = 1'b0;
            end_d   = 1'b0;
            err_d   = 1'b0;
            ovf_d   = ovf_q;
            to_d    = '0;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.start_seen = start_q;
    assign bus.end_seen   = end_q;
    assign bus.error      = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_maple_in.sv
// Self-checking bench for maple_in: drives Maple frames on the pins and compares
// observed framing events and bytes against the frames it sent.
module tb_maple_in;
    localparam int unsigned TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maple_in_if bus_if();
    maple_in #(.TIMEOUT(TIMEOUT), .TO_W(13)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int          n_start = 0, n_end = 0, n_err = 0, n_dv = 0, n_viol = 0;
    int unsigned err_cyc = 0;
    logic [7:0]  rxq[$];
    logic        p_dv = 0, p_st = 0, p_en = 0, p_er = 0;
    always @(negedge clk) begin
        if (bus_if.start_seen) n_start++;
        if (bus_if.end_seen)   n_end++;
        if (bus_if.error) begin n_err++; err_cyc = cyc; end
        if (bus_if.data_valid) begin n_dv++; rxq.push_back(bus_if.data); end
        if (bus_if.data_valid && bus_if.end_seen) n_viol++;
        if ((bus_if.data_valid && p_dv) || (bus_if.start_seen && p_st) ||
            (bus_if.end_seen && p_en) || (bus_if.error && p_er)) n_viol++;
        p_dv = bus_if.data_valid;
        p_st = bus_if.start_seen;
        p_en = bus_if.end_seen;
        p_er = bus_if.error;
    end

    int          n_vec = 0, n_bad = 0;
    int          tl = 4;
    int unsigned chg_cyc = 0;
    logic [7:0]  expq[$];
    int          rx_rd = 0;
    int          b_start, b_end, b_err, b_viol;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a, input logic b);
        if (a !== bus_if.pin1 || b !== bus_if.pin5) chg_cyc = cyc;
        bus_if.pin1 = a;
        bus_if.pin5 = b;
        repeat (tl) @(negedge clk);
    endtask

    // Start pattern: pin1 low, n pulses on pin5 (ending low), pin1 high
    task automatic send_start(input int n);
        step(1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0);
            if (i != n - 1) step(1'b0, 1'b1);
        end
        step(1'b1, 1'b0);
    endtask

    // First n bits of x, MSB first, alternating phase A / phase B
    task automatic send_bits(input logic [7:0] x, input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            b = x[7-k];
            if (k % 2 == 0) begin
                step(1'b1, 1'b0); step(1'b1, b); step(1'b0, b);
            end else begin
                step(1'b0, 1'b1); step(b, 1'b1); step(b, 1'b0);
            end
        end
    endtask

    task automatic send_end();
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    task automatic mark();
        b_start = n_start; b_end = n_end; b_err = n_err; b_viol = n_viol;
    endtask

    // Compare framing counts and received bytes against the model
    task automatic check_frame(input string tag, input int e_start, input int e_end, input int e_err);
        repeat (10) @(negedge clk);
        chk({tag, "_start"}, n_start - b_start, e_start);
        chk({tag, "_end"},   n_end - b_end, e_end);
        chk({tag, "_err"},   n_err - b_err, e_err);
        chk({tag, "_pulse"}, n_viol - b_viol, 0);
        chk({tag, "_busy"},  int'(bus_if.busy), 0);
        chk({tag, "_nbytes"}, rxq.size() - rx_rd, expq.size());
        while (expq.size() > 0 && rx_rd < rxq.size()) begin
            chk({tag, "_byte"}, int'(rxq[rx_rd]), int'(expq.pop_front()));
            rx_rd++;
        end
        expq.delete();
        rx_rd = rxq.size();
    endtask

    task automatic good_frame(input string tag, input int nbytes);
        logic [7:0] x;
        mark();
        send_start(4);
        for (int i = 0; i < nbytes; i++) begin
            x = 8'($urandom);
            expq.push_back(x);
            send_bits(x, 8);
        end
        send_end();
        check_frame(tag, 1, 1, 0);
    endtask

    initial begin
        logic [7:0] seq[3];
        logic [7:0] x;
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        rst = 1'b0;
        bus_if.pin1 = 1'b1; bus_if.pin5 = 1'b1;
        bus_if.enable = 1'b1; bus_if.fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", int'(bus_if.data), 0);
        chk("rst_dv", int'(bus_if.data_valid), 0);
        chk("rst_ovf", int'(bus_if.overflow), 0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_err", int'(bus_if.error), 0);
        rst = 1'b1;
        mark();
        repeat (100) @(negedge clk);
        check_frame("idle", 0, 0, 0);
        chk("idle_dv", n_dv, 0);

        // Single byte 0xA5 at 4 clk per tick
        mark();
        send_start(4);
        expq.push_back(8'hA5);
        send_bits(8'hA5, 8);
        send_end();
        check_frame("a5", 1, 1, 0);

        // Three bytes in order
        mark();
        send_start(4);
        for (int i = 0; i < 3; i++) begin
            expq.push_back(seq[i]);
            send_bits(seq[i], 8);
        end
        send_end();
        check_frame("seq3", 1, 1, 0);

        // Short start pattern, then recover with a good frame
        mark();
        send_start(3);
        step(1'b1, 1'b1);
        check_frame("badstart", 0, 0, 1);
        good_frame("after_bad", 1);

        // Five bits then silence: abort exactly TIMEOUT cycles after the last edge
        mark();
        x = 8'($urandom);
        send_start(4);
        send_bits(x, 5);
        repeat (TIMEOUT + 20) @(negedge clk);
        chk("to_err", n_err - b_err, 1);
        chk("to_when", int'(err_cyc - chg_cyc), int'(TIMEOUT + 3));
        chk("to_busy", int'(bus_if.busy), 0);
        chk("to_nbytes", rxq.size() - rx_rd, 0);
        step(1'b1, x[3]);
        step(1'b1, 1'b1);
        check_frame("to_tail", 1, 0, 1);

        // FIFO full on the second byte: dropped, error, sticky overflow
        mark();
        send_start(4);
        x = 8'($urandom);
        expq.push_back(x);
        send_bits(x, 8);
        bus_if.fifo_full = 1'b1;
        send_bits(8'($urandom), 8);
        send_end();
        bus_if.fifo_full = 1'b0;
        check_frame("ovf", 1, 1, 1);
        chk("ovf_set", int'(bus_if.overflow), 1);
        repeat (50) @(negedge clk);
        chk("ovf_hold", int'(bus_if.overflow), 1);
        mark();
        send_start(4);
        chk("ovf_clr", int'(bus_if.overflow), 0);
        send_end();
        check_frame("ovf_next", 1, 1, 0);

        // Transmitter takes the bus mid-frame: silent return to idle
        mark();
        send_start(4);
        send_bits(8'hC0, 3);
        bus_if.enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_busy", int'(bus_if.busy), 0);
        step(1'b1, 1'b1);
        bus_if.enable = 1'b1;
        check_frame("en_off", 1, 0, 0);
        good_frame("en_back", 2);

        // Randomised frames
        for (int f = 0; f < 20; f++) begin
            tl = int'($urandom_range(2, 6));
            good_frame("rnd", int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
